// File: rtl/fib_arbiter_if.sv
// Request/response bundle between two Fibonacci clients and the shared engine.
// master = client side, slave = fib_arbiter.
interface fib_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int IDXW  = 7
);
  logic            req0_valid;
  logic [IDXW-1:0] req0_n;
  logic            req0_ready;
  logic            req1_valid;
  logic [IDXW-1:0] req1_n;
  logic            req1_ready;
  logic            resp_valid;
  logic            resp_ready;
  logic            resp_id;
  logic [WIDTH-1:0] resp_value;
  logic            resp_ovf;
  logic            busy;

  modport master (
    output req0_valid, req0_n, req1_valid, req1_n, resp_ready,
    input  req0_ready, req1_ready, resp_valid, resp_id, resp_value, resp_ovf, busy
  );

  modport slave (
    input  req0_valid, req0_n, req1_valid, req1_n, resp_ready,
    output req0_ready, req1_ready, resp_valid, resp_id, resp_value, resp_ovf, busy
  );
endinterface

// File: rtl/fib_arbiter.sv
// Shared iterative Fibonacci engine with a two-requester round-robin front end.
// Returns F(n) mod 2^WIDTH, the requester id and an overflow flag.
module fib_arbiter #(
  parameter int WIDTH = 32,
  parameter int IDXW  = 7
) (
  input  logic             clk,
  input  logic             rst,
  fib_arbiter_if.slave     bus
);

  typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

  state_t           state, state_nx;
  logic             prio;
  logic             id;
  logic [IDXW-1:0]  cnt;
  logic [WIDTH-1:0] a, b;
  logic             ovf_a, ovf_b;

  logic             grant0, grant1, accept, acc_id, done;
  logic [IDXW-1:0]  acc_n;
  logic [WIDTH:0]   sum;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst && state == IDLE) begin
      if (bus.req0_valid && (!bus.req1_valid || !prio)) grant0 = 1'b1;
      else if (bus.req1_valid)                          grant1 = 1'b1;
    end
  end

  assign accept = grant0 | grant1;
  assign acc_id = grant1;
  assign acc_n  = grant1 ? bus.req1_n : bus.req0_n;
  assign sum    = {1'b0, a} + {1'b0, b};
  assign done   = (cnt == IDXW'(1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept)         state_nx = RUN;
      RUN:     if (done)           state_nx = RESP;
      RESP:    if (bus.resp_ready) state_nx = IDLE;
      default:                     state_nx = IDLE;
    endcase
  end

  // Datapath. Every request takes max(n-1,1) RUN steps; the start pair
  // (a,b) is chosen so that a = F(n) after the last step. For n<2 the
  // single step shifts b into a, so b is preloaded with F(n).
  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio  <= 1'b0;
      id    <= 1'b0;
      cnt   <= '0;
      a     <= '0;
      b     <= '0;
      ovf_a <= 1'b0;
      ovf_b <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          id    <= acc_id;
          prio  <= ~acc_id;
          ovf_a <= 1'b0;
          ovf_b <= 1'b0;
          if (acc_n >= IDXW'(2)) begin
            a   <= WIDTH'(1);
            b   <= WIDTH'(1);
            cnt <= acc_n - IDXW'(1);
          end else begin
            a   <= (acc_n == '0) ? WIDTH'(1) : '0;
            b   <= (acc_n == '0) ? '0 : WIDTH'(1);
            cnt <= IDXW'(1);
          end
        end
        RUN: begin
          a     <= b;
          b     <= sum[WIDTH-1:0];
          // ovf_a tracks only the term in a, so carries beyond F(n) stay in ovf_b.
          ovf_a <= ovf_b;
          ovf_b <= ovf_a | ovf_b | sum[WIDTH];
          cnt   <= cnt - IDXW'(1);
        end
        default: ;
      endcase
    end
  end

  // Outputs: resp_* and busy decode registered state only.
  always_comb begin
    bus.req0_ready = grant0;
    bus.req1_ready = grant1;
    bus.resp_valid = (state == RESP);
    bus.busy       = (state != IDLE);
    bus.resp_id    = id;
    bus.resp_value = a;
    bus.resp_ovf   = ovf_a;
  end

endmodule
